// File: rtl/plot_pkg.sv
// Shared types and screen geometry for the VGA pixel write-port arbiter.
package plot_pkg;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int C_W      = 9;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [C_W-1:0] colour;
  } pixel_t;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;
endpackage

// File: rtl/plot_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after i_ptr, with wrap.
module rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
  output logic [NUM_REQ-1:0]         o_win,
  output logic                       o_any
);
  localparam int PW = $clog2(NUM_REQ);

  int unsigned     w_idx;
  logic [PW-1:0]   w_sel;

  always_comb begin
    o_win = '0;
    o_any = 1'b0;
    w_idx = '0;
    w_sel = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_idx = (32'(i_ptr) + i) % NUM_REQ;
      w_sel = w_idx[PW-1:0];
      if (!o_any && i_req[w_sel]) begin
        o_win[w_sel] = 1'b1;
        o_any        = 1'b1;
      end
    end
  end
endmodule

// File: rtl/plot_arbiter.sv
// Round-robin arbiter sharing the VGA adapter write port between pixel producers,
// with bounded bursts, off-screen clipping and a registered write port.
module plot_arbiter
  import plot_pkg::X_W, plot_pkg::Y_W, plot_pkg::C_W;
#(
  parameter int NUM_REQ   = 4,
  parameter int BURST_MAX = 16,
  parameter int SCREEN_W  = 160,
  parameter int SCREEN_H  = 120
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     last,
  input  logic [NUM_REQ*X_W-1:0] reqX,
  input  logic [NUM_REQ*Y_W-1:0] reqY,
  input  logic [NUM_REQ*C_W-1:0] reqColour,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [X_W-1:0]         oX,
  output logic [Y_W-1:0]         oY,
  output logic [C_W-1:0]         oColour,
  output logic                   oPlot,
  output logic                   busy,
  output logic                   clip_err
);
  import plot_pkg::*;

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(BURST_MAX + 1);

  arb_state_t         r_state;
  logic [NUM_REQ-1:0] r_gnt;
  logic [PW-1:0]      r_ptr;
  logic [CW-1:0]      r_cnt;
  pixel_t             r_px;
  logic               r_plot;
  logic               r_clip;

  logic [NUM_REQ-1:0] w_win;
  logic               w_any;
  logic [PW-1:0]      w_gidx;
  pixel_t             w_px;
  logic               w_req_g;
  logic               w_last_g;
  logic               w_onscr;
  logic               w_full;
  logic [CW-1:0]      w_cnt_nxt;
  logic [PW-1:0]      w_ptr_nxt;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .i_req (req),
    .i_ptr (r_ptr),
    .o_win (w_win),
    .o_any (w_any)
  );

  always_comb begin
    w_gidx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (r_gnt[i]) w_gidx = PW'(i);
    end
    w_px.x      = reqX[w_gidx*X_W +: X_W];
    w_px.y      = reqY[w_gidx*Y_W +: Y_W];
    w_px.colour = reqColour[w_gidx*C_W +: C_W];
    w_req_g     = |(req & r_gnt);
    w_last_g    = |(last & r_gnt);
    w_onscr     = (int'(w_px.x) < SCREEN_W) && (int'(w_px.y) < SCREEN_H);
    w_cnt_nxt   = r_cnt + CW'(1);
    w_full      = (w_cnt_nxt == CW'(BURST_MAX));
    w_ptr_nxt   = (w_gidx == PW'(NUM_REQ - 1)) ? '0 : w_gidx + PW'(1);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_px    <= '0;
      r_plot  <= 1'b0;
      r_clip  <= 1'b0;
    end else begin
      r_plot <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_gnt   <= w_win;
            r_cnt   <= '0;
            r_state <= GRANT;
          end
        end
        GRANT: begin
          if (!w_req_g) begin
            r_gnt   <= '0;
            r_ptr   <= w_ptr_nxt;
            r_state <= IDLE;
          end else begin
            r_cnt <= w_cnt_nxt;
            // Clipped pixels complete the handshake but leave the write port untouched.
            if (w_onscr) begin
              r_plot <= 1'b1;
              r_px   <= w_px;
            end else begin
              r_clip <= 1'b1;
            end
            if (w_last_g || w_full) begin
              r_gnt   <= '0;
              r_ptr   <= w_ptr_nxt;
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt      = r_gnt;
  assign oX       = r_px.x;
  assign oY       = r_px.y;
  assign oColour  = r_px.colour;
  assign oPlot    = r_plot;
  assign busy     = (r_state == GRANT);
  assign clip_err = r_clip;
endmodule

// File: tb/tb_plot_arbiter.sv
// Directed bench for plot_arbiter: vector table plus hand-written multi-cycle sequences.
module tb_plot_arbiter;
  logic        clock = 1'b0;
  logic        resetn;
  logic [3:0]  req, last;
  logic [31:0] reqX;
  logic [27:0] reqY;
  logic [35:0] reqColour;
  logic [3:0]  gnt;
  logic [7:0]  oX;
  logic [6:0]  oY;
  logic [8:0]  oColour;
  logic        oPlot, busy, clip_err;

  int total = 0;
  int bad   = 0;

  plot_arbiter #(.NUM_REQ(4), .BURST_MAX(16), .SCREEN_W(160), .SCREEN_H(120)) dut (
    .clock(clock), .resetn(resetn), .req(req), .last(last),
    .reqX(reqX), .reqY(reqY), .reqColour(reqColour),
    .gnt(gnt), .oX(oX), .oY(oY), .oColour(oColour),
    .oPlot(oPlot), .busy(busy), .clip_err(clip_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] req;
    logic [3:0] last;
    int         sel;
    logic [7:0] x;
    logic [6:0] y;
    logic [8:0] c;
    logic [3:0] e_gnt;
    logic       e_plot;
    logic [7:0] e_x;
    logic [6:0] e_y;
    logic [8:0] e_c;
    logic       e_clip;
  } vec_t;

  vec_t tbl[12];

  function automatic vec_t mk(input logic [3:0] rq, input logic [3:0] ls, input int sel,
                              input logic [7:0] x, input logic [6:0] y, input logic [8:0] c,
                              input logic [3:0] eg, input logic ep, input logic [7:0] ex,
                              input logic [6:0] ey, input logic [8:0] ec, input logic ecl);
    vec_t v;
    v.req = rq; v.last = ls; v.sel = sel; v.x = x; v.y = y; v.c = c;
    v.e_gnt = eg; v.e_plot = ep; v.e_x = ex; v.e_y = ey; v.e_c = ec; v.e_clip = ecl;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic lane(input int i, input logic [7:0] x, input logic [6:0] y, input logic [8:0] c);
    reqX[i*8 +: 8]      = x;
    reqY[i*7 +: 7]      = y;
    reqColour[i*9 +: 9] = c;
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int r = lo; r < hi; r++) begin
      req  = tbl[r].req;
      last = tbl[r].last;
      lane(tbl[r].sel, tbl[r].x, tbl[r].y, tbl[r].c);
      step();
      chk($sformatf("row%0d gnt", r),  gnt,      tbl[r].e_gnt);
      chk($sformatf("row%0d plot", r), oPlot,    tbl[r].e_plot);
      chk($sformatf("row%0d x", r),    oX,       tbl[r].e_x);
      chk($sformatf("row%0d y", r),    oY,       tbl[r].e_y);
      chk($sformatf("row%0d c", r),    oColour,  tbl[r].e_c);
      chk($sformatf("row%0d clip", r), clip_err, tbl[r].e_clip);
      chk($sformatf("row%0d busy", r), busy,     |tbl[r].e_gnt);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ord[5];
    ord = '{3, 0, 1, 2, 3};

    // single requester 2 stream, then clip sequence on requester 0
    tbl[0]  = mk(4'b0100, 4'b0000, 2,  10,  20, 9'h1C0, 4'b0100, 0,   1,   1, 9'h001, 0);
    tbl[1]  = mk(4'b0100, 4'b0000, 2,  10,  20, 9'h1C0, 4'b0100, 1,  10,  20, 9'h1C0, 0);
    tbl[2]  = mk(4'b0100, 4'b0000, 2,  11,  20, 9'h1C0, 4'b0100, 1,  11,  20, 9'h1C0, 0);
    tbl[3]  = mk(4'b0100, 4'b0000, 2,  12,  20, 9'h1C0, 4'b0100, 1,  12,  20, 9'h1C0, 0);
    tbl[4]  = mk(4'b0100, 4'b0000, 2,  13,  20, 9'h1C0, 4'b0100, 1,  13,  20, 9'h1C0, 0);
    tbl[5]  = mk(4'b0100, 4'b0100, 2,  14,  20, 9'h1C0, 4'b0000, 1,  14,  20, 9'h1C0, 0);
    tbl[6]  = mk(4'b0000, 4'b0000, 2,  14,  20, 9'h1C0, 4'b0000, 0,  14,  20, 9'h1C0, 0);
    tbl[7]  = mk(4'b0001, 4'b0000, 0, 160,   5, 9'h111, 4'b0001, 0,  70,  30, 9'h03F, 0);
    tbl[8]  = mk(4'b0001, 4'b0000, 0, 160,   5, 9'h111, 4'b0001, 0,  70,  30, 9'h03F, 1);
    tbl[9]  = mk(4'b0001, 4'b0000, 0, 159, 119, 9'h155, 4'b0001, 1, 159, 119, 9'h155, 1);
    tbl[10] = mk(4'b0001, 4'b0000, 0,   0, 120, 9'h0AA, 4'b0001, 0, 159, 119, 9'h155, 1);
    tbl[11] = mk(4'b0001, 4'b0000, 0, 159, 119, 9'h1FF, 4'b0001, 1, 159, 119, 9'h1FF, 1);

    resetn = 1'b0;
    req    = 4'b1111;
    last   = 4'b0000;
    reqX = '0; reqY = '0; reqColour = '0;
    for (int i = 0; i < 4; i++) lane(i, 8'(i + 1), 7'(i + 1), 9'(i + 1));
    repeat (3) step();
    chk("rst gnt", gnt, 0);
    chk("rst plot", oPlot, 0);
    chk("rst busy", busy, 0);
    chk("rst clip", clip_err, 0);
    chk("rst x", oX, 0);
    chk("rst y", oY, 0);
    chk("rst c", oColour, 0);

    resetn = 1'b1;
    step();
    chk("first gnt", gnt, 4'b0001);
    chk("first busy", busy, 1);
    chk("first plot", oPlot, 0);
    step();
    chk("first pix plot", oPlot, 1);
    chk("first pix x", oX, 1);
    chk("first pix c", oColour, 1);
    req = 4'b0000;
    step();
    chk("abandon gnt", gnt, 0);
    chk("abandon plot", oPlot, 0);
    chk("abandon busy", busy, 0);

    run_rows(0, 7);

    // all requesting with long jobs: ptr is 3 after requester 2 released
    req  = 4'b1111;
    last = 4'b0000;
    for (int g = 0; g < 5; g++) begin
      step();
      chk($sformatf("rr%0d gnt", g), gnt, 4'b0001 << ord[g]);
      chk($sformatf("rr%0d bubble plot", g), oPlot, 0);
      for (int k = 0; k < 16; k++) begin
        lane(ord[g], 8'(ord[g] * 40 + k), 7'(ord[g]), 9'(k));
        step();
        chk($sformatf("rr%0d.%0d plot", g, k), oPlot, 1);
        chk($sformatf("rr%0d.%0d x", g, k), oX, 32'(ord[g] * 40 + k));
        chk($sformatf("rr%0d.%0d gnt", g, k), gnt, (k == 15) ? 4'b0000 : (4'b0001 << ord[g]));
      end
    end
    req = 4'b0000;
    step();
    chk("rr idle plot", oPlot, 0);
    chk("rr idle gnt", gnt, 0);

    // requester 1 abandons after 3 pixels while requester 3 waits
    lane(3, 70, 30, 9'h03F);
    req = 4'b1010;
    step();
    chk("drop gnt1", gnt, 4'b0010);
    for (int k = 0; k < 3; k++) begin
      lane(1, 8'(50 + k), 10, 9'h0F0);
      step();
      chk($sformatf("drop pix%0d plot", k), oPlot, 1);
      chk($sformatf("drop pix%0d x", k), oX, 32'(50 + k));
    end
    req = 4'b1000;
    step();
    chk("drop release gnt", gnt, 0);
    chk("drop release plot", oPlot, 0);
    step();
    chk("waiter gnt3", gnt, 4'b1000);
    chk("waiter busy", busy, 1);
    step();
    chk("waiter plot", oPlot, 1);
    chk("waiter x", oX, 70);
    chk("waiter y", oY, 30);
    chk("waiter c", oColour, 9'h03F);
    req = 4'b0000;
    step();
    chk("waiter release gnt", gnt, 0);

    run_rows(7, 12);

    // asynchronous reset right after an accepted pixel
    resetn = 1'b0;
    #1;
    chk("midrst plot", oPlot, 0);
    chk("midrst gnt", gnt, 0);
    chk("midrst clip", clip_err, 0);
    chk("midrst busy", busy, 0);
    chk("midrst x", oX, 0);
    req  = 4'b1111;
    last = 4'b0000;
    lane(0, 5, 5, 9'h005);
    step();
    resetn = 1'b1;
    step();
    chk("restart gnt", gnt, 4'b0001);
    step();
    chk("restart plot", oPlot, 1);
    chk("restart x", oX, 5);

    // last coinciding with the 16th pixel: single release, ptr advances to 1
    req = 4'b0001;
    for (int k = 1; k < 16; k++) begin
      lane(0, 8'(5 + k), 5, 9'h005);
      last = (k == 15) ? 4'b0001 : 4'b0000;
      step();
      chk($sformatf("both%0d plot", k), oPlot, 1);
      chk($sformatf("both%0d gnt", k), gnt, (k == 15) ? 4'b0000 : 4'b0001);
    end
    last = 4'b0000;
    req  = 4'b0011;
    step();
    chk("both next gnt", gnt, 4'b0010);
    req = 4'b0000;
    step();
    chk("final gnt", gnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
